// File: rtl/lcd_init_seq.sv
// ST7789 power-up sequencer: pulses lcd_rst, then streams the init table as {dc, byte} words.
// Define LCD_FILL_EN to follow the table with RAMWR and a solid-colour screen fill.
module lcd_init_seq #(
    parameter int unsigned RST_LOW_CYC  = 500_000,
    parameter int unsigned RST_WAIT_CYC = 6_000_000,
    parameter int unsigned CMD_WAIT_CYC = 6_000_000,
    parameter int unsigned FILL_PIXELS  = 57_600,
    parameter logic [15:0] FILL_COLOR   = 16'hF800
) (
    input  logic       sys_clk_50MHz,
    input  logic       sys_rst_n,
    input  logic       restart,
    input  logic       wr_done,
    output logic       en_write,
    output logic [8:0] data,
    output logic       lcd_rst,
    output logic       busy,
    output logic       init_done
);

    typedef enum logic [2:0] {
        StRstLow, StRstWait, StSend, StWaitDone, StDelay, StDone
    } state_e;

    // A zero-length wait still costs one clock.
    function automatic logic [23:0] cyc_limit(input int unsigned cyc);
        return (cyc == 0) ? 24'd0 : 24'(cyc - 1);
    endfunction

    function automatic logic [8:0] init_word(input logic [2:0] i);
        case (i)
            3'd0:    return 9'h001;
            3'd1:    return 9'h011;
            3'd2:    return 9'h03A;
            3'd3:    return 9'h155;
            3'd4:    return 9'h036;
            3'd5:    return 9'h100;
            3'd6:    return 9'h021;
            default: return 9'h029;
        endcase
    endfunction

    localparam logic [23:0] RstLowLim  = cyc_limit(RST_LOW_CYC);
    localparam logic [23:0] RstWaitLim = cyc_limit(RST_WAIT_CYC);
    localparam logic [23:0] CmdWaitLim = cyc_limit(CMD_WAIT_CYC);

    state_e      state_q;
    logic [23:0] cnt_q;
    logic [2:0]  idx_q;
    logic        is_wait;
    logic        adv;
    logic        adv_done;
    logic [8:0]  adv_word;

`ifdef LCD_FILL_EN
    localparam logic [17:0] FillBytes = 18'(2 * FILL_PIXELS);
    logic        fill_q;
    logic [17:0] fill_cnt_q;
`else
    logic unused_fill_cfg;
    assign unused_fill_cfg = ^{FILL_COLOR, FILL_PIXELS};
`endif

    // adv: the current word is closed and the next one (or DONE) is due.
    always_comb begin
        adv_done = 1'b0;
        adv_word = init_word(idx_q + 3'd1);
        is_wait  = (idx_q <= 3'd1);
`ifdef LCD_FILL_EN
        if (fill_q) begin
            is_wait  = 1'b0;
            adv_done = (fill_cnt_q == FillBytes);
            adv_word = fill_cnt_q[0] ? {1'b1, FILL_COLOR[7:0]} : {1'b1, FILL_COLOR[15:8]};
        end else if (idx_q == 3'd7) begin
            adv_word = 9'h02C;
        end
`else
        adv_done = (idx_q == 3'd7);
`endif
        adv = ((state_q == StWaitDone) && wr_done && !is_wait) ||
              ((state_q == StDelay) && (cnt_q == CmdWaitLim));
    end

    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StRstLow;
            cnt_q      <= '0;
            idx_q      <= '0;
            en_write   <= 1'b0;
            data       <= '0;
            lcd_rst    <= 1'b0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
`ifdef LCD_FILL_EN
            fill_q     <= 1'b0;
            fill_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                StRstLow: begin
                    if (cnt_q == RstLowLim) begin
                        state_q <= StRstWait;
                        cnt_q   <= '0;
                        lcd_rst <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                StRstWait: begin
                    if (cnt_q == RstWaitLim) begin
                        state_q  <= StSend;
                        idx_q    <= '0;
                        en_write <= 1'b1;
                        data     <= init_word(3'd0);
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                StSend: begin
                    en_write <= 1'b0;
                    state_q  <= StWaitDone;
                end
                StWaitDone: begin
                    if (wr_done && is_wait) begin
                        state_q <= StDelay;
                        cnt_q   <= '0;
                    end
                end
                StDelay: cnt_q <= cnt_q + 24'd1;
                StDone: begin
                    if (restart) begin
                        state_q   <= StRstLow;
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        lcd_rst   <= 1'b0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
`ifdef LCD_FILL_EN
                        fill_q    <= 1'b0;
`endif
                    end
                end
                default: state_q <= StRstLow;
            endcase

            if (adv) begin
                if (adv_done) begin
                    state_q   <= StDone;
                    busy      <= 1'b0;
                    init_done <= 1'b1;
                end else begin
                    state_q  <= StSend;
                    en_write <= 1'b1;
                    data     <= adv_word;
`ifdef LCD_FILL_EN
                    if (fill_q) begin
                        fill_cnt_q <= fill_cnt_q + 18'd1;
                    end else if (idx_q == 3'd7) begin
                        fill_q     <= 1'b1;
                        fill_cnt_q <= '0;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
`else
                    idx_q <= idx_q + 3'd1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_init_seq.sv
// Bench for lcd_init_seq: random-latency writer model, expected word list and strobe timing
// derived from the table and wait rules; covers spurious wr_done, mid-run reset and restart.
module tb_lcd_init_seq;

    localparam int RstLow  = 4;
    localparam int RstWait = 6;
    localparam int CmdWait = 5;
    localparam int FillPix = 3;
    localparam logic [15:0] FillColor = 16'hF800;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       wr_done = 1'b0;
    logic       en_write;
    logic [8:0] data;
    logic       lcd_rst;
    logic       busy;
    logic       init_done;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [8:0] last_word = 9'h000;
    logic [8:0] exp_words[$];
    bit         exp_wait[$];

    lcd_init_seq #(
        .RST_LOW_CYC (RstLow),
        .RST_WAIT_CYC(RstWait),
        .CMD_WAIT_CYC(CmdWait),
        .FILL_PIXELS (FillPix),
        .FILL_COLOR  (FillColor)
    ) dut (
        .sys_clk_50MHz(clk),
        .sys_rst_n    (rst_n),
        .restart      (restart),
        .wr_done      (wr_done),
        .en_write     (en_write),
        .data         (data),
        .lcd_rst      (lcd_rst),
        .busy         (busy),
        .init_done    (init_done)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic build_model();
        exp_words = {9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h100, 9'h021, 9'h029};
        exp_wait  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef LCD_FILL_EN
        exp_words.push_back(9'h02C);
        exp_wait.push_back(1'b0);
        for (int p = 0; p < FillPix; p++) begin
            exp_words.push_back({1'b1, FillColor[15:8]});
            exp_wait.push_back(1'b0);
            exp_words.push_back({1'b1, FillColor[7:0]});
            exp_wait.push_back(1'b0);
        end
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_en"}, 32'(en_write), 32'd0);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_lcd_rst"}, 32'(lcd_rst), 32'd0);
        check({tag, "_init_done"}, 32'(init_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Called at the first negedge where lcd_rst is low for this run.
    task automatic run_seq(input bit spur, input int abort_idx, input int restart_idx);
        int low_cnt;
        int rise;
        int exp_cyc;
        int spur_cyc;
        int lat;
        int w;
        int n;
        low_cnt = 0;
        while (lcd_rst !== 1'b1 && low_cnt < 100) begin
            check("busy_in_reset", 32'(busy), 32'd1);
            low_cnt++;
            step();
        end
        check("rst_low_len", 32'(low_cnt), 32'(RstLow));
        rise     = cyc;
        exp_cyc  = rise + RstWait;
        spur_cyc = spur ? rise + 2 : -1;
        for (int i = 0; i < exp_words.size(); i++) begin
            n = 0;
            while (en_write !== 1'b1 && n < 100) begin
                check("data_hold", 32'(data), 32'(last_word));
                wr_done = (cyc == spur_cyc);
                step();
                n++;
            end
            wr_done = 1'b0;
            check("strobe_cycle", 32'(cyc), 32'(exp_cyc));
            check("word", 32'(data), 32'(exp_words[i]));
            check("busy_run", 32'(busy), 32'd1);
            check("init_done_run", 32'(init_done), 32'd0);
            last_word = exp_words[i];
            if (i == abort_idx) return;
            if (i == restart_idx) restart = 1'b1;
            step();
            restart = 1'b0;
            check("strobe_width", 32'(en_write), 32'd0);
            lat = int'($urandom_range(1, 20));
            for (int k = 1; k < lat; k++) begin
                check("no_strobe_wait", 32'(en_write), 32'd0);
                check("data_hold", 32'(data), 32'(last_word));
                step();
            end
            wr_done = 1'b1;
            w = cyc;
            step();
            wr_done = 1'b0;
            exp_cyc  = w + 1 + (exp_wait[i] ? CmdWait : 0);
            spur_cyc = (spur && exp_wait[i]) ? w + 2 : -1;
        end
        check("done_cycle", 32'(cyc), 32'(exp_cyc));
        check("init_done", 32'(init_done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        for (int k = 0; k < 15; k++) begin
            wr_done = (k == 3);
            step();
            check("idle_no_strobe", 32'(en_write), 32'd0);
            check("idle_done", 32'(init_done), 32'd1);
        end
        wr_done = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_init_done", 32'(init_done), 32'd0);
    endtask

    initial begin
        build_model();
        repeat (3) step();
        check_reset_values("reset");

        // Reset release and full run.
        rst_n = 1'b1;
        run_seq(1'b0, -1, -1);

        // Spurious wr_done in RST_WAIT and DELAY.
        do_restart();
        run_seq(1'b1, -1, -1);

        // Reset while waiting on word 4.
        do_restart();
        run_seq(1'b0, 4, -1);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        last_word = 9'h000;
        step();
        step();
        check_reset_values("held_reset");
        rst_n = 1'b1;
        run_seq(1'b0, -1, -1);

        // Restart pulses while a word is being sent must be ignored.
        for (int r = 0; r < 3; r++) begin
            do_restart();
            run_seq(1'(r == 1), -1, int'($urandom_range(0, exp_words.size() - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
